// File: rtl/shared_sub_arb_pkg.sv
// sub_pkg: shared types and constants for the shared subtractor arbiter.
// Holds the FSM state encoding, the requester-id type and the default
// operand width used by shared_sub_arb and sub_unit.
package sub_pkg;

  // Default operand / difference width in bits.
  localparam int unsigned SUB_WIDTH_DEFAULT = 4;

  // Controller states: waiting for a request, computing, presenting result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Identifies which of the two requesters owns an operation.
  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  // Pick the requester that did not win last time (round-robin helper).
  function automatic req_id_t other_req(input req_id_t last);
    other_req = (last == REQ1) ? REQ0 : REQ1;
  endfunction

endpackage

// File: rtl/shared_sub_arb_sub_unit.sv
// sub_unit: purely combinational WIDTH-bit subtractor with borrow in/out.
// diff = (a - b - bin) mod 2^WIDTH; bor = 1 when a < b + bin (unsigned).
module sub_unit
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             bor_o
);

  // One extra bit catches the borrow: b + bin never exceeds 2^WIDTH, so the
  // top bit of the zero-extended difference is set exactly when it underflows.
  logic [WIDTH:0] ext_s;

  // Extended subtraction and split into difference and borrow-out.
  always_comb begin
    ext_s  = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, bin_i};
    diff_o = ext_s[WIDTH-1:0];
    bor_o  = ext_s[WIDTH];
  end

endmodule

// File: rtl/shared_sub_arb.sv
// shared_sub_arb: two requesters time-share one subtract unit.
// One operation in flight: IDLE accepts, EXEC computes from registered
// operands, RESP holds the result until the consumer takes it.
// Optional feature macro: SHARED_SUB_ARB_RR_EN
//   defined   -> round-robin on contention (last-served pointer kept)
//   undefined -> fixed priority, requester 0 always wins contention
module shared_sub_arb
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_bin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_bin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_diff,
  output logic             rsp_bor
);

  state_e           state_q, state_d;

  // Captured operands of the accepted request.
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_bin_q, op_bin_d;
  req_id_t          op_id_q, op_id_d;

  // Result registers; they keep the last result after RESP is left.
  logic [WIDTH-1:0] rsp_diff_q, rsp_diff_d;
  logic             rsp_bor_q, rsp_bor_d;
  req_id_t          rsp_id_q, rsp_id_d;

  // Arbitration and datapath helpers.
  req_id_t          grant_s;
  logic             rdy0_s, rdy1_s;
  logic             accept_s;
  logic [WIDTH-1:0] diff_s;
  logic             bor_s;

`ifdef SHARED_SUB_ARB_RR_EN
  req_id_t          last_q, last_d;
`endif

  // Choose which requester is offered the unit; only depends on valids
  // (and the pointer), never on rsp_ready.
  always_comb begin
    grant_s = REQ0;
    if (req0_valid && req1_valid) begin
`ifdef SHARED_SUB_ARB_RR_EN
      grant_s = other_req(last_q);
`else
      grant_s = REQ0;
`endif
    end else if (req1_valid) begin
      grant_s = REQ1;
    end else begin
      grant_s = REQ0;
    end
  end

  // Next-state, capture and handshake logic of the controller.
  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_bin_d   = op_bin_q;
    op_id_d    = op_id_q;
    rsp_diff_d = rsp_diff_q;
    rsp_bor_d  = rsp_bor_q;
    rsp_id_d   = rsp_id_q;
    rdy0_s     = 1'b0;
    rdy1_s     = 1'b0;
    accept_s   = 1'b0;
    case (state_q)
      IDLE: begin
        rdy0_s   = req0_valid && (grant_s == REQ0);
        rdy1_s   = req1_valid && (grant_s == REQ1);
        accept_s = rdy0_s || rdy1_s;
        if (accept_s) begin
          if (grant_s == REQ1) begin
            op_a_d   = req1_a;
            op_b_d   = req1_b;
            op_bin_d = req1_bin;
          end else begin
            op_a_d   = req0_a;
            op_b_d   = req0_b;
            op_bin_d = req0_bin;
          end
          op_id_d = grant_s;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        rsp_diff_d = diff_s;
        rsp_bor_d  = bor_s;
        rsp_id_d   = op_id_q;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef SHARED_SUB_ARB_RR_EN
  // Pointer follows every accepted request.
  always_comb begin
    if (accept_s) begin
      last_d = grant_s;
    end else begin
      last_d = last_q;
    end
  end

  // Last-served pointer register; reset to requester 1 so requester 0
  // wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // State, operand and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_a_q     <= {WIDTH{1'b0}};
      op_b_q     <= {WIDTH{1'b0}};
      op_bin_q   <= 1'b0;
      op_id_q    <= REQ0;
      rsp_diff_q <= {WIDTH{1'b0}};
      rsp_bor_q  <= 1'b0;
      rsp_id_q   <= REQ0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_bin_q   <= op_bin_d;
      op_id_q    <= op_id_d;
      rsp_diff_q <= rsp_diff_d;
      rsp_bor_q  <= rsp_bor_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  // The single shared subtract unit, fed only from captured operands.
  sub_unit #(
    .WIDTH (WIDTH)
  ) u_sub_unit (
    .a_i    (op_a_q),
    .b_i    (op_b_q),
    .bin_i  (op_bin_q),
    .diff_o (diff_s),
    .bor_o  (bor_s)
  );

  assign req0_ready = rdy0_s;
  assign req1_ready = rdy1_s;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_diff   = rsp_diff_q;
  assign rsp_bor    = rsp_bor_q;

endmodule

// File: tb/tb_shared_sub_arb.sv
// Directed bench for shared_sub_arb (WIDTH=4): table of single operations,
// then hand-written latency/backpressure/reset/contention sequences and an
// exhaustive operand sweep on requester 0.
module tb_shared_sub_arb;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         req0_valid, req0_ready, req0_bin;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_bin;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_bor;
  logic [W-1:0] rsp_diff;

  int n_vec;
  int n_bad;

  typedef struct {
    int who;
    int a;
    int b;
    int bin;
    int exp_diff;
    int exp_bor;
  } vec_t;

  vec_t tbl[7];

  shared_sub_arb #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_bin   (req0_bin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_bin   (req1_bin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_diff   (rsp_diff),
    .rsp_bor    (rsp_bor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_req(input int who, input logic v, input int a, input int b, input int bin);
    logic [W-1:0] av, bv;
    av = a[W-1:0];
    bv = b[W-1:0];
    if (who == 0) begin
      req0_valid = v; req0_a = av; req0_b = bv; req0_bin = bin[0];
    end else begin
      req1_valid = v; req1_a = av; req1_b = bv; req1_bin = bin[0];
    end
  endtask

  // One complete transaction from IDLE; called at a negedge, returns at a
  // negedge with the DUT back in IDLE.
  task automatic op(input int who, input int a, input int b, input int bin,
                    input int exp_diff, input int exp_bor);
    int got;
    logic rdy;
    got = 0;
    set_req(who, 1'b1, a, b, bin);
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      rdy = (who == 0) ? req0_ready : req1_ready;
      if (rdy === 1'b1) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("grant", got, 1);
    if (got == 0) begin
      set_req(who, 1'b0, 0, 0, 0);
      @(negedge clk);
      return;
    end
    @(posedge clk);                    // accept edge T
    @(negedge clk);
    set_req(who, 1'b0, 0, 0, 0);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_readies", {req0_ready, req1_ready}, 0);
    @(negedge clk);                    // after edge T+1
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, who);
    chk("rsp_diff", rsp_diff, exp_diff);
    chk("rsp_bor", rsp_bor, exp_bor);
    @(negedge clk);                    // back in IDLE
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("hold_diff", rsp_diff, exp_diff);
  endtask

  initial begin
    int nresp;
    int ids[4];
    int exp_ids[4];
    int d;

    n_vec = 0;
    n_bad = 0;
    tbl[0] = '{0, 9, 3, 0, 6, 0};
    tbl[1] = '{1, 2, 5, 1, 12, 1};
    tbl[2] = '{1, 0, 0, 1, 15, 1};
    tbl[3] = '{0, 15, 0, 0, 15, 0};
    tbl[4] = '{1, 0, 15, 1, 0, 1};
    tbl[5] = '{0, 8, 8, 0, 0, 0};
    tbl[6] = '{1, 8, 7, 1, 0, 0};
`ifdef SHARED_SUB_ARB_RR_EN
    exp_ids = '{0, 1, 0, 1};
`else
    exp_ids = '{0, 0, 0, 0};
`endif

    rst = 1'b1;
    rsp_ready = 1'b0;
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_diff", rsp_diff, 0);
    chk("rst_rsp_bor", rsp_bor, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table of isolated single-requester operations.
    for (int i = 0; i < 7; i++) begin
      op(tbl[i].who, tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].exp_diff, tbl[i].exp_bor);
    end

    // Backpressure: result held 5 cycles, nobody accepted meanwhile.
    set_req(0, 1'b1, 5, 1, 1);
    rsp_ready = 1'b0;
    #1 chk("bp_grant0", req0_ready, 1);
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b1, 4, 4, 0);
    #1 chk("bp_exec_rdy1", req1_ready, 0);
    @(negedge clk);
    repeat (5) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_diff", rsp_diff, 3);
      chk("bp_bor", rsp_bor, 0);
      chk("bp_id", rsp_id, 0);
      chk("bp_readies", {req0_ready, req1_ready}, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_valid", rsp_valid, 0);
    chk("bp_idle_rdy1", req1_ready, 1);
    chk("bp_idle_hold", rsp_diff, 3);
    set_req(1, 1'b0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("bp_no_accept", rsp_valid, 0);

    // Reset while EXEC: request dropped, outputs cleared.
    set_req(1, 1'b1, 6, 1, 0);
    rsp_ready = 1'b1;
    #1 chk("rm_grant1", req1_ready, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    set_req(1, 1'b0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rm_valid", rsp_valid, 0);
    chk("rm_diff", rsp_diff, 0);
    chk("rm_bor", rsp_bor, 0);
    chk("rm_id", rsp_id, 0);
    repeat (4) begin
      @(negedge clk);
      chk("rm_dropped", rsp_valid, 0);
    end

    // Contention: both valid continuously, consumer always ready.
    set_req(0, 1'b1, 7, 2, 0);
    set_req(1, 1'b1, 3, 8, 0);
    rsp_ready = 1'b1;
    nresp = 0;
    for (int c = 0; c < 40 && nresp < 4; c++) begin
      #1;
      chk("cont_one_grant", req0_ready & req1_ready, 0);
      if (rsp_valid) begin
        ids[nresp] = rsp_id;
        chk("cont_diff", rsp_diff, rsp_id ? 11 : 5);
        chk("cont_bor", rsp_bor, rsp_id ? 1 : 0);
        nresp++;
      end
      @(negedge clk);
    end
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0);
    chk("cont_count", nresp, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < nresp) chk("cont_id", ids[i], exp_ids[i]);
    end
    repeat (3) @(negedge clk);
    chk("cont_quiet", rsp_valid, 0);

    // Exhaustive operand sweep on requester 0.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int bin = 0; bin < 2; bin++) begin
          d = a - b - bin;
          op(0, a, b, bin, (d + 16) % 16, (d < 0) ? 1 : 0);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/shared_sub_arb.md
SHARED_SUB_ARB -- requirements
Module: shared_sub_arb

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand/difference width in bits.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports, clock and reset first:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a, req0_b  input  WIDTH  requester 0 minuend, subtrahend
- req0_bin  input  1  requester 0 borrow-in
- req1_valid, req1_ready, req1_a, req1_b, req1_bin  as requester 0, for requester 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_id  output  1  requester that owns the result
- rsp_diff  output  WIDTH  (a - b - bin) mod 2^WIDTH
- rsp_bor  output  1  1 iff a < b + bin (unsigned, WIDTH+1-bit compare)

Function
REQ-004 SHALL time-share one subtract unit between two requesters using FSM states IDLE, EXEC, RESP.
REQ-005 SHALL, in IDLE, assert reqX_ready=1 only for the granted requester, and only when reqX_valid=1; all readies SHALL be 0 in EXEC and RESP.
REQ-006 SHALL accept a request when reqX_valid & reqX_ready at an edge, register a, b, bin and id, and move to EXEC.
REQ-007 SHALL, in EXEC, compute diff/bor from the registered operands, register them, and move to RESP at the next edge.
REQ-008 SHALL, in RESP, hold rsp_valid=1 with stable rsp_id/rsp_diff/rsp_bor until rsp_ready=1, then return to IDLE at that edge.
REQ-009 SHALL give latency: accept at edge T, rsp_valid=1 from edge T+1; one transaction in flight at most.
REQ-010 SHALL keep rsp_valid=0 outside RESP; rsp_* values SHALL hold their last result while rsp_valid=0.
REQ-011 SHALL, with only one requester valid in IDLE, grant that requester regardless of arbitration history.
REQ-012 SHALL, with both valid in IDLE, grant according to REQ-017/REQ-018.
REQ-013 SHALL wrap diff modulo 2^WIDTH: a=0,b=0,bin=1 gives diff=all ones, bor=1.
REQ-014 SHALL have no combinational path from rsp_ready to any reqX_ready.
REQ-015 SHALL not return to IDLE without rsp_ready; a requester deasserting valid while not granted loses nothing.

Reset
REQ-016 SHALL, on rst=1 at an edge in any state, go to IDLE, drop any in-flight transaction, clear rsp_valid, rsp_id, rsp_diff, rsp_bor to 0, and set the last-served pointer to 1 (so requester 0 wins first contention).

Configuration
REQ-017 SHALL, with SHARED_SUB_ARB_RR_EN defined, arbitrate round-robin: on contention, grant the requester not served last; the pointer updates on every accept.
REQ-018 SHALL, without SHARED_SUB_ARB_RR_EN, use fixed priority: requester 0 always wins contention; the pointer is not implemented.

Structure
REQ-019 SHALL place in a shared package sub_pkg: the FSM state enum (IDLE/EXEC/RESP), the requester-id type, and the default WIDTH constant.
REQ-020 SHALL instantiate one sub-module sub_unit (combinational WIDTH-bit a, b, bin -> diff, bor); the arbiter/FSM stays in shared_sub_arb.

Verification
REQ-021 Bench SHALL cover, WIDTH=4:
- single: req0 a=9,b=3,bin=0, rsp_ready=1 -> accept edge T, rsp_valid from T+1, diff=6, bor=0, id=0.
- borrow/wrap: req1 a=2,b=5,bin=1 -> diff=12 (4'b1100), bor=1, id=1; a=0,b=0,bin=1 -> diff=15, bor=1.
- contention: both valid continuously, rsp_ready=1 -> RR_EN: ids 0,1,0,1; without: ids 0,0,0,0.
- backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, both readies 0, no new accept; rsp_ready=1 -> IDLE next edge.
- reset mid-op: rst=1 during EXEC -> next cycle IDLE, rsp_valid=0, rsp_* all 0, dropped request not responded; next contention grants req0.
- exhaustive: all 16x16x2 operand combinations on req0 -> diff/bor match (a - b - bin) model.
